// File: rtl/c_mul_ctrl.sv
// Iterative radix-2 shift-add multiplier controller for RV32M MUL/MULH/MULHSU/MULHU.
// Holds the front of the pipeline via o_con_mulpause while the 32 iterations run.
`timescale 1ns/1ps
module c_mul_ctrl #(
    parameter int unsigned W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    input  logic [1:0]   i_op,
    input  logic [W-1:0] i_rs1,
    input  logic [W-1:0] i_rs2,
    input  logic         i_flush,
    output logic         o_con_mulpause,
    output logic [W-1:0] o_result,
    output logic         o_done
);
    localparam int unsigned CntW = $clog2(W);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    mag1_q, mag1_d;
    logic            neg_q, neg_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    result_q, result_d;

    logic            rs1_neg, rs2_neg;
    logic [W-1:0]    rs1_mag, rs2_mag;
    logic [W:0]      sum;
    logic [2*W-1:0]  acc_step;
    logic [2*W-1:0]  prod;

    always_comb begin
        // rs1 is signed for every op but MULHU; rs2 only for MUL/MULH.
        rs1_neg = (i_op != 2'b11) & i_rs1[W-1];
        rs2_neg = ~i_op[1] & i_rs2[W-1];
        rs1_mag = rs1_neg ? (~i_rs1 + 1'b1) : i_rs1;
        rs2_mag = rs2_neg ? (~i_rs2 + 1'b1) : i_rs2;

        // The carry of the add lands in hi's MSB after the shift, so the carry flop is implicit.
        sum      = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag1_q} : '0);
        acc_step = {sum, acc_q[W-1:1]};
        prod     = neg_q ? (~acc_step + 1'b1) : acc_step;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mag1_d   = mag1_q;
        neg_d    = neg_q;
        op_d     = op_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    state_d = StCalc;
                    cnt_d   = '0;
                    acc_d   = {{W{1'b0}}, rs2_mag};
                    mag1_d  = rs1_mag;
                    neg_d   = rs1_neg ^ rs2_neg;
                    op_d    = i_op;
                end
            end
            StCalc: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(W - 1)) begin
                    state_d  = StDone;
                    result_d = (op_q == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (i_flush) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            mag1_q   <= '0;
            neg_q    <= 1'b0;
            op_q     <= 2'b00;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mag1_q   <= mag1_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign o_con_mulpause = ~i_flush & (((state_q == StIdle) & i_valid) | (state_q == StCalc));
    assign o_result       = result_q;
    assign o_done         = (state_q == StDone);

endmodule
